// File: rtl/serial_comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_comparator_pkg
//  Description : Shared FSM state encoding and relation-flag record for the
//                serial magnitude comparator (and its parallel siblings).
//  Revision    : 1.0
// ============================================================================
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Common relation record so parallel and serial comparators report alike.
    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } relation_t;

    localparam relation_t C_REL_RESET = '{eq: 1'b0, lt: 1'b0, gt: 1'b0};

    function automatic relation_t pack_relation(input logic decided,
                                                input logic lt,
                                                input logic gt);
        relation_t rel;
        rel.eq = ~decided;
        rel.lt = lt;
        rel.gt = gt;
        return rel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_comparator
//  Description : Bit-serial MSB-first unsigned magnitude comparator with a
//                start/valid/done handshake. Define EARLY_EXIT_EN to finish on
//                the first differing bit pair.
//  Revision    : 1.0
// ============================================================================
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_valid,
    input  logic                         a_bit,
    input  logic                         b_bit,
    output logic                         busy,
    output logic                         done,
    output logic                         A_eq_B,
    output logic                         A_lt_B,
    output logic                         A_gt_B,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_decided;
    logic             r_lt;
    logic             r_gt;
    relation_t        r_rel;

    logic             w_take;
    logic             w_first_diff;
    logic             w_last;
    logic             w_finish;
    logic             w_decided_nx;
    logic             w_lt_nx;
    logic             w_gt_nx;

    assign w_take       = (r_state == ST_COMPARE) && bit_valid;
    assign w_first_diff = w_take && !r_decided && (a_bit ^ b_bit);
    assign w_last       = w_take && (r_bit_cnt == C_LAST);

`ifdef EARLY_EXIT_EN
    assign w_finish = w_last || w_first_diff;
`else
    assign w_finish = w_last;
`endif

    // Capture values including the pair being consumed this cycle, so the
    // flags can be loaded on the same edge that enters DONE.
    assign w_decided_nx = r_decided | w_first_diff;
    assign w_lt_nx      = w_first_diff ? b_bit : r_lt;
    assign w_gt_nx      = w_first_diff ? a_bit : r_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_finish) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (r_state == ST_COMPARE);
        done    = (r_state == ST_DONE);
        A_eq_B  = r_rel.eq;
        A_lt_B  = r_rel.lt;
        A_gt_B  = r_rel.gt;
        bit_cnt = r_bit_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_rel     <= C_REL_RESET;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_bit_cnt <= '0;
                r_decided <= 1'b0;
                r_lt      <= 1'b0;
                r_gt      <= 1'b0;
            end else if (w_take) begin
                r_bit_cnt <= r_bit_cnt + C_ONE;
                r_decided <= w_decided_nx;
                r_lt      <= w_lt_nx;
                r_gt      <= w_gt_nx;
            end
            if (w_finish) begin
                r_rel <= pack_relation(w_decided_nx, w_lt_nx, w_gt_nx);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_comparator
//  Description : Randomized self-checking bench for serial_comparator, run on
//                a WIDTH=4 and a WIDTH=8 instance against an arithmetic model.
//  Revision    : 1.0
// ============================================================================
module tb_serial_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [2];
    logic        valid_s [2];
    logic        a_s     [2];
    logic        b_s     [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        eq_o    [2];
    logic        lt_o    [2];
    logic        gt_o    [2];
    logic [2:0]  cnt4;
    logic [3:0]  cnt8;
    logic [31:0] cnt_o   [2];
    logic [2:0]  exp_rel [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .bit_valid(valid_s[0]),
        .a_bit(a_s[0]), .b_bit(b_s[0]), .busy(busy_o[0]), .done(done_o[0]),
        .A_eq_B(eq_o[0]), .A_lt_B(lt_o[0]), .A_gt_B(gt_o[0]), .bit_cnt(cnt4)
    );

    serial_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_s[1]), .bit_valid(valid_s[1]),
        .a_bit(a_s[1]), .b_bit(b_s[1]), .busy(busy_o[1]), .done(done_o[1]),
        .A_eq_B(eq_o[1]), .A_lt_B(lt_o[1]), .A_gt_B(gt_o[1]), .bit_cnt(cnt8)
    );

    assign cnt_o[0] = 32'(cnt4);
    assign cnt_o[1] = 32'(cnt8);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] flags(input int d);
        return {29'd0, eq_o[d], lt_o[d], gt_o[d]};
    endfunction

    // Model: relation from plain integer comparison; early-exit count is the
    // MSB-first position of the highest differing bit.
    task automatic run_cmp(input int d, input logic [31:0] a_in, input logic [31:0] b_in,
                           input logic [63:0] gaps, input bit poke);
        int          w;
        logic [31:0] mask, a, b, x, exp_cnt;
        logic [2:0]  rel;
        w    = (d == 0) ? 4 : 8;
        mask = (32'd1 << w) - 32'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        x    = a ^ b;
        rel  = (a == b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
        exp_cnt = 32'(w);
`ifdef EARLY_EXIT_EN
        if (x != 0) exp_cnt = 32'(w) - 32'($clog2(x + 32'd1) - 1);
`endif
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        chk("busy_after_start", {31'd0, busy_o[d]}, 32'd1);
        chk("flags_held_at_start", flags(d), {29'd0, exp_rel[d]});
        for (int k = 0; k < int'(exp_cnt); k++) begin
            for (int g = 0; g < int'(gaps[2*k +: 2]); g++) begin
                @(posedge clk); #1;
                chk("cnt_in_gap", cnt_o[d], 32'(k));
            end
            valid_s[d] = 1'b1;
            a_s[d]     = a[w-1-k];
            b_s[d]     = b[w-1-k];
            start_s[d] = poke && (k == 0);
            @(posedge clk); #1;
            valid_s[d] = 1'b0;
            start_s[d] = 1'b0;
            if (k < int'(exp_cnt) - 1) begin
                chk("no_early_done", {31'd0, done_o[d]}, 32'd0);
                chk("flags_held_mid", flags(d), {29'd0, exp_rel[d]});
            end
        end
        chk("done_pulse", {31'd0, done_o[d]}, 32'd1);
        chk("busy_low_at_done", {31'd0, busy_o[d]}, 32'd0);
        chk("relation", flags(d), {29'd0, rel});
        chk("bit_cnt", cnt_o[d], exp_cnt);
        exp_rel[d] = rel;
        // stray bits in IDLE must be ignored
        valid_s[d] = 1'b1;
        a_s[d]     = 1'($urandom);
        b_s[d]     = 1'($urandom);
        @(posedge clk); #1;
        valid_s[d] = 1'b0;
        chk("done_one_cycle", {31'd0, done_o[d]}, 32'd0);
        chk("flags_held_idle", flags(d), {29'd0, rel});
        @(posedge clk); #1;
        chk("cnt_held_idle", cnt_o[d], exp_cnt);
    endtask

    task automatic check_reset(input int d);
        chk("rst_busy", {31'd0, busy_o[d]}, 32'd0);
        chk("rst_done", {31'd0, done_o[d]}, 32'd0);
        chk("rst_flags", flags(d), 32'd0);
        chk("rst_cnt", cnt_o[d], 32'd0);
    endtask

    task automatic reset_mid(input int d);
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid_s[d] = 1'b1;
            a_s[d]     = 1'b1;
            b_s[d]     = 1'b1;
            @(posedge clk); #1;
        end
        valid_s[d] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rel[0] = 3'b000;
        exp_rel[1] = 3'b000;
        check_reset(d);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", {31'd0, done_o[d]}, 32'd0);
            chk("idle_after_rst", {31'd0, busy_o[d]}, 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            valid_s[d] = 1'b0;
            a_s[d]     = 1'b0;
            b_s[d]     = 1'b0;
            exp_rel[d] = 3'b000;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset(0);
        check_reset(1);

        // directed scenarios (WIDTH=4)
        run_cmp(0, 32'hA, 32'hA, 64'd0, 1'b0);
        run_cmp(0, 32'h6, 32'h5, 64'd0, 1'b0);
        run_cmp(0, 32'h3, 32'h8, {56'd0, 2'd1, 2'd0, 2'd2, 2'd0}, 1'b0);
        run_cmp(0, 32'h9, 32'h9, 64'd0, 1'b1);
        reset_mid(0);
        run_cmp(0, 32'hC, 32'h4, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("gt_held_idle", flags(0), 32'b001);
        run_cmp(0, 32'h2, 32'h7, {56'd0, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b0);
        // WIDTH=8 rerun
        run_cmp(1, 32'hFF, 32'hFE, 64'd0, 1'b0);

        // randomized
        for (int i = 0; i < 40; i++) begin
            int          d;
            logic [31:0] a, b;
            logic [63:0] gaps;
            d = i % 2;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'd1 << $urandom_range(0, (d == 0) ? 3 : 7));
                default: b = $urandom;
            endcase
            gaps = {$urandom, $urandom} & {32{2'b01}};
            if ($urandom_range(0, 3) == 0) gaps = {$urandom, $urandom};
            run_cmp(d, a, b, gaps, 1'($urandom));
            if (i == 20) reset_mid(d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_comparator.md
# serial_comparator

Bit-serial magnitude comparator for two unsigned WIDTH-bit operands delivered one bit pair per cycle, MSB first. It is the serial-link counterpart to the lab's parallel comparators: it sits at the receiving end of a serial operand stream and produces the same three mutually exclusive relation flags. A start/valid/done handshake frames each comparison. Results are held until the next comparison begins.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new comparison; honoured only in IDLE.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  current bit of A, MSB first.
- b_bit  input  1  current bit of B, MSB first.
- busy  output  1  high in COMPARE.
- done  output  1  one-cycle pulse when the result becomes valid.
- A_eq_B  output  1  A equals B (held).
- A_lt_B  output  1  A less than B (held).
- A_gt_B  output  1  A greater than B (held).
- bit_cnt  output  $clog2(WIDTH+1)  bit pairs consumed in the current or last comparison.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE: start=1 moves to COMPARE. Clears bit_cnt, the decided flag and the lt/gt capture registers. Any bit_valid in the same cycle is ignored.
- COMPARE, bit_valid=1: bit_cnt increments.
  - If not yet decided and a_bit!=b_bit: set decided. Capture gt=a_bit, lt=b_bit.
  - Bits after the first difference never change the capture.
- COMPARE, bit_valid=0: hold state and counters; gaps of any length are legal.
- COMPARE exits to DONE when the WIDTH-th pair is consumed (bit_cnt reaches WIDTH).
- DONE, for exactly one cycle:
  - done=1.
  - Relation flags update: A_gt_B=gt, A_lt_B=lt, A_eq_B=!decided.
  - Then return to IDLE.
- Relation flags change only on the DONE cycle or on reset. Exactly one flag is high after the first completed comparison.
- start while busy or in DONE is ignored.
- bit_valid in IDLE is ignored.

## Timing
- Reset values: busy=0, done=0, A_eq_B=0, A_lt_B=0, A_gt_B=0, bit_cnt=0, state=IDLE.
- Reset mid-comparison aborts immediately; no done pulse follows.
- start sampled at edge N puts busy=1 from N+1.
- The last valid pair sampled at edge M gives done=1 and updated flags from M+1, with busy=0 in that same cycle. Latency is one cycle from the last bit.
- The earliest next start is accepted during the DONE cycle's successor (IDLE).
- Minimum comparison with no gaps: WIDTH+2 cycles from start to done deassertion.

## Configuration
- EARLY_EXIT_EN defined: COMPARE exits to DONE on the first differing pair, at any bit_cnt.
  - bit_cnt then reports the position of the difference.
  - The transmitter must stop sending remaining bits; any that arrive in IDLE are ignored.
  - Equal operands still take all WIDTH pairs.
- EARLY_EXIT_EN undefined: always consume exactly WIDTH pairs.

## Structure
- Shared package holds:
  - the state enum (IDLE, COMPARE, DONE);
  - a relation struct/encoding {eq, lt, gt} so the parallel and serial comparators report identically.
- Single module. No sub-module is needed; the FSM, counter and capture logic are all small.

## Test plan
Scenarios use WIDTH=4 unless stated.
- A=4'b1010, B=4'b1010, contiguous bits → done at cycle 5 after start; A_eq_B=1, others 0; bit_cnt=4.
- A=4'b0110, B=4'b0101 → A_gt_B=1.
  - EARLY_EXIT_EN off: bit_cnt=4.
  - EARLY_EXIT_EN on: done after the 3rd pair, bit_cnt=3.
- A=4'b0011, B=4'b1000, bit_valid toggled 1,0,0,1,1,0,1 → A_lt_B=1. Gaps must not be counted; bit_cnt=4.
- Mid-stream checks:
  - start pulsed during COMPARE has no effect.
  - rst asserted after 2 pairs returns all outputs to reset values; no done follows.
  - A fresh start then completes a correct comparison.
- Back-to-back:
  - Comparison 1 (A>B) leaves A_gt_B held high through IDLE.
  - Comparison 2 (A<B) changes the flags only on its done cycle.
  - WIDTH=8 rerun: A=8'hFF, B=8'hFE → A_gt_B=1.
